// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: geometry-derived default widths, arbiter state
// encoding and round-robin grant encoding.
package ddr2_pkg;

    localparam int BA_BITS  = 3;
    localparam int ROW_BITS = 13;
    localparam int COL_BITS = 10;
    localparam int DQ_BITS  = 16;

    localparam int DEF_ADDR_WIDTH = ROW_BITS + COL_BITS + BA_BITS;
    // The controller moves two DQ words per user-clock beat.
    localparam int DEF_DATA_WIDTH = DQ_BITS * 2;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_D,
        WR_B,
        RD_A,
        RD_D
    } arb_state_t;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } gnt_t;

endpackage

// File: rtl/ddr2_axi_arb_burst_len_chk.sv
// Beat counter shared by the W and R data phases; pulses err when last and
// the programmed length disagree.
module burst_len_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] len_q,
    input  logic       beat,
    input  logic       last,
    input  logic       clear,
    output logic [7:0] beat_cnt,
    output logic       err
);

    logic [7:0] beat_cnt_q;
    logic [7:0] beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clear) begin
            beat_cnt_d = 8'd0;
        end else if (beat) begin
            // Wraps modulo 256, so a runaway burst keeps hitting len_q.
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= 8'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
    assign err      = beat && (last ? (beat_cnt_q != len_q) : (beat_cnt_q == len_q));

endmodule

// File: rtl/ddr2_axi_arb.sv
// Round-robin scheduler sharing one ddr2_ctrl AXI slave port between a write
// requester and a read requester, one burst in flight at a time.
module ddr2_axi_arb
    import ddr2_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_end,

    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic                  s_axi_wlast,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  s_axi_rlast,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,

    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic                  m_axi_wlast,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic                  m_axi_rlast,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,

    output logic                  grant_wr,
    output logic                  grant_rd,
    output logic                  len_err,
    input  logic                  err_clr
);

    arb_state_t state_q, state_d;
    gnt_t       last_grant_q, last_grant_d;
    logic [7:0] len_q, len_d;
    logic       len_err_q, len_err_d;

    logic       chk_clear;
    logic       chk_beat;
    logic       chk_last;
    logic       chk_err;
    logic [7:0] beat_cnt;

    assign m_axi_awaddr = s_axi_awaddr;
    assign m_axi_awlen  = s_axi_awlen;
    assign m_axi_wlast  = s_axi_wlast;
    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_araddr = s_axi_araddr;
    assign m_axi_arlen  = s_axi_arlen;
    assign s_axi_rlast  = m_axi_rlast;
    assign s_axi_rdata  = m_axi_rdata;

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        len_d         = len_q;
        chk_clear     = 1'b0;
        chk_beat      = 1'b0;
        chk_last      = 1'b0;
        m_axi_awvalid = 1'b0;
        s_axi_awready = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (init_end) begin
                    if (s_axi_awvalid && s_axi_arvalid) begin
                        state_d = (last_grant_q == GNT_RD) ? WR_A : RD_A;
                    end else if (s_axi_awvalid) begin
                        state_d = WR_A;
                    end else if (s_axi_arvalid) begin
                        state_d = RD_A;
                    end
                end
            end
            WR_A: begin
                m_axi_awvalid = s_axi_awvalid;
                s_axi_awready = m_axi_awready;
                if (s_axi_awvalid && m_axi_awready) begin
                    len_d     = s_axi_awlen;
                    chk_clear = 1'b1;
                    state_d   = WR_D;
                end
            end
            WR_D: begin
                m_axi_wvalid = s_axi_wvalid;
                s_axi_wready = m_axi_wready;
                chk_beat     = s_axi_wvalid && m_axi_wready;
                chk_last     = s_axi_wlast;
                if (chk_beat && s_axi_wlast) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                s_axi_bvalid = m_axi_bvalid;
                m_axi_bready = s_axi_bready;
                if (m_axi_bvalid && s_axi_bready) begin
                    last_grant_d = GNT_WR;
                    state_d      = IDLE;
                end
            end
            RD_A: begin
                m_axi_arvalid = s_axi_arvalid;
                s_axi_arready = m_axi_arready;
                if (s_axi_arvalid && m_axi_arready) begin
                    len_d     = s_axi_arlen;
                    chk_clear = 1'b1;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                s_axi_rvalid = m_axi_rvalid;
                m_axi_rready = s_axi_rready;
                chk_beat     = m_axi_rvalid && s_axi_rready;
                chk_last     = m_axi_rlast;
                if (chk_beat && m_axi_rlast) begin
                    last_grant_d = GNT_RD;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh error outranks a simultaneous clear.
    always_comb begin
        len_err_d = len_err_q;
        if (err_clr) begin
            len_err_d = 1'b0;
        end
        if (chk_err) begin
            len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_RD;
            len_q        <= 8'd0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            len_err_q    <= len_err_d;
        end
    end

    burst_len_chk u_len_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .len_q    (len_q),
        .beat     (chk_beat),
        .last     (chk_last),
        .clear    (chk_clear),
        .beat_cnt (beat_cnt),
        .err      (chk_err)
    );

    assign grant_wr = (state_q == WR_A) || (state_q == WR_D) || (state_q == WR_B);
    assign grant_rd = (state_q == RD_A) || (state_q == RD_D);
    assign len_err  = len_err_q;

endmodule
